// File: rtl/sum_sq.sv
// rtl/sum_sq.sv - i^2 + q^2 of one signed I/Q pair via two bit-serial shift-add multipliers
module sum_sq #(
  parameter int DIN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [DIN_W-1:0] din_i,
  input  logic signed [DIN_W-1:0] din_q,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic [2*DIN_W-1:0]      dout,
  output logic                    dout_valid,
  input  logic                    dout_ready
);

  localparam int DOUT_W = 2 * DIN_W;
  localparam int CW     = (DIN_W > 1) ? $clog2(DIN_W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [DIN_W-1:0]    mag_i_q, mag_i_d, mag_q_q, mag_q_d;
  logic [DOUT_W-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DOUT_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                din_ready_q, din_ready_d;
  logic [DOUT_W-1:0]   step_i, step_q;

  // Partial products for the current bit; |min| = 2^(DIN_W-1) still fits the unsigned magnitude.
  always_comb begin
    step_i = '0;
    step_q = '0;
    if (mag_i_q[cnt_q]) step_i = {{DIN_W{1'b0}}, mag_i_q} << cnt_q;
    if (mag_q_q[cnt_q]) step_q = {{DIN_W{1'b0}}, mag_q_q} << cnt_q;
  end

  always_comb begin
    state_d      = state_q;
    mag_i_d      = mag_i_q;
    mag_q_d      = mag_q_q;
    acc_i_d      = acc_i_q;
    acc_q_d      = acc_q_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    din_ready_d  = din_ready_q;
    case (state_q)
      IDLE: begin
        din_ready_d = 1'b1;
        if (din_valid && din_ready_q) begin
          mag_i_d     = din_i[DIN_W-1] ? (~din_i + 1'b1) : din_i;
          mag_q_d     = din_q[DIN_W-1] ? (~din_q + 1'b1) : din_q;
          acc_i_d     = '0;
          acc_q_d     = '0;
          cnt_d       = '0;
          din_ready_d = 1'b0;
          state_d     = CALC;
        end
      end
      CALC: begin
        acc_i_d = acc_i_q + step_i;
        acc_q_d = acc_q_q + step_q;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(DIN_W - 1)) begin
          dout_d       = acc_i_q + step_i + acc_q_q + step_q;
          dout_valid_d = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          din_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mag_i_q      <= '0;
      mag_q_q      <= '0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mag_i_q      <= mag_i_d;
      mag_q_q      <= mag_q_d;
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      din_ready_q  <= din_ready_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign din_ready  = din_ready_q;

endmodule
